// File: rtl/layer_act_buffer.sv
// layer_act_buffer: per-layer activation store with init sweep, completion masks, clear and errors (LAYER_ACT_BUFFER_RELU_EN clamps negative writes to 0)
module layer_act_buffer #(
  parameter int DATA_W      = 16,
  parameter int MAX_NEURONS = 8,
  parameter int MAX_DEPTH   = 4,
  parameter int LAYER_W     = $clog2(MAX_DEPTH),
  parameter int NEURON_W    = $clog2(MAX_NEURONS)
) (
  input  logic                          CLK,
  input  logic                          RST,
  output logic                          ready,
  input  logic                          wr_en,
  input  logic [LAYER_W-1:0]            wr_layer,
  input  logic [NEURON_W-1:0]           wr_neuron,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_err,
  input  logic                          clr_en,
  input  logic [LAYER_W-1:0]            clr_layer,
  input  logic                          rd_req,
  input  logic [LAYER_W-1:0]            rd_layer,
  input  logic [MAX_NEURONS*DATA_W-1:0] master_in,
  output logic                          rd_valid,
  output logic                          rd_err,
  output logic [MAX_NEURONS*DATA_W-1:0] rd_data,
  output logic [MAX_NEURONS*DATA_W-1:0] last_layer,
  output logic [MAX_DEPTH-1:0]          layer_full
);
  localparam int MW = MAX_NEURONS - 1;
  typedef enum logic {INIT, IDLE} state_t;
  state_t state, state_nx;
  logic [LAYER_W-1:0] cnt;
  logic [DATA_W-1:0] mem [1:MAX_DEPTH-1][MAX_NEURONS];
  logic [MW-1:0] mask [1:MAX_DEPTH-1];
  logic sweep, wr_acc, rd_acc, rd_oob;
  logic [DATA_W-1:0] wdata;
  logic [MAX_NEURONS*DATA_W-1:0] rd_vec;
`ifdef LAYER_ACT_BUFFER_RELU_EN
  assign wdata = wr_data[DATA_W-1] ? '0 : wr_data;
`else
  assign wdata = wr_data;
`endif
  always_comb begin
    state_nx = (state == INIT && int'(cnt) == MAX_DEPTH - 1) ? IDLE : state;
    sweep = state == INIT;
    wr_acc = ready && wr_en && wr_layer != '0 && int'(wr_layer) < MAX_DEPTH && int'(wr_neuron) < MW;
    rd_acc = ready && rd_req;
    rd_oob = int'(rd_layer) >= MAX_DEPTH;
    rd_vec = master_in;
    for (int l = 1; l < MAX_DEPTH; l++)
      for (int n = 0; n < MAX_NEURONS; n++)
        if (int'(rd_layer) == l) rd_vec[n*DATA_W +: DATA_W] = mem[l][n];
    last_layer = '0;
    for (int n = 0; n < MAX_NEURONS; n++)
      last_layer[n*DATA_W +: DATA_W] = mem[MAX_DEPTH-1][n];
  end
  always_ff @(posedge CLK)
    if (!RST)
      for (int l = 1; l < MAX_DEPTH; l++)
        for (int n = 0; n < MAX_NEURONS; n++)
          if (sweep && int'(cnt) == l) mem[l][n] <= (n == MW) ? DATA_W'(1) : '0;
          else if (wr_acc && int'(wr_layer) == l && int'(wr_neuron) == n) mem[l][n] <= wdata;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
      cnt <= LAYER_W'(1);
      ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_err <= 1'b0;
      wr_err <= 1'b0;
      rd_data <= '0;
      layer_full <= MAX_DEPTH'(1);
      for (int l = 1; l < MAX_DEPTH; l++) mask[l] <= '0;
    end else begin
      state <= state_nx;
      if (sweep) cnt <= cnt + 1'b1;
      ready <= state == IDLE;
      wr_err <= ready && wr_en && !wr_acc;
      rd_valid <= rd_acc;
      rd_err <= rd_acc && rd_oob;
      if (rd_acc && !rd_oob) rd_data <= rd_vec;
      layer_full[0] <= 1'b1;
      // clear first, then OR in the accepted write so a same-cycle write survives the clear
      for (int l = 1; l < MAX_DEPTH; l++) begin
        mask[l] <= ((ready && clr_en && int'(clr_layer) == l) ? '0 : mask[l])
                 | ((wr_acc && int'(wr_layer) == l) ? MW'(1) << wr_neuron : '0);
        layer_full[l] <= &mask[l];
      end
    end
  end
endmodule

// File: tb/tb_layer_act_buffer.sv
// tb_layer_act_buffer: directed self-checking bench for layer_act_buffer
module tb_layer_act_buffer;
  localparam int DW = 16, NN = 8, MD = 4, LW = 3, NW = 3, VW = NN * DW;
  logic CLK = 0, RST = 1;
  logic ready, wr_en = 0, wr_err, clr_en = 0, rd_req = 0, rd_valid, rd_err;
  logic [LW-1:0] wr_layer = 0, clr_layer = 0, rd_layer = 0;
  logic [NW-1:0] wr_neuron = 0;
  logic [DW-1:0] wr_data = 0;
  logic [VW-1:0] master_in = 0, rd_data, last_layer, exp_v;
  logic [MD-1:0] layer_full;
  int tests = 0, fails = 0;

  layer_act_buffer #(.DATA_W(DW), .MAX_NEURONS(NN), .MAX_DEPTH(MD), .LAYER_W(LW), .NEURON_W(NW)) dut (
    .CLK(CLK), .RST(RST), .ready(ready), .wr_en(wr_en), .wr_layer(wr_layer), .wr_neuron(wr_neuron),
    .wr_data(wr_data), .wr_err(wr_err), .clr_en(clr_en), .clr_layer(clr_layer), .rd_req(rd_req),
    .rd_layer(rd_layer), .master_in(master_in), .rd_valid(rd_valid), .rd_err(rd_err),
    .rd_data(rd_data), .last_layer(last_layer), .layer_full(layer_full));

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [LW-1:0] l, input logic [NW-1:0] n, input logic [DW-1:0] d);
    wr_en = 1; wr_layer = l; wr_neuron = n; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic rd(input logic [LW-1:0] l);
    rd_req = 1; rd_layer = l;
    tick();
    rd_req = 0;
  endtask

  task automatic test_reset;
    tick();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    tests++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || wr_err !== 1'b0) begin fails++; $display("FAIL reset_pulses got %b%b%b want 000", rd_valid, rd_err, wr_err); end
    tests++; if (layer_full !== 4'b0001) begin fails++; $display("FAIL reset_full got %b want 0001", layer_full); end
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    RST = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (ready !== (i == 3)) begin fails++; $display("FAIL init_ready[%0d] got %b want %b", i, ready, i == 3); end
    end
    rd(2);
    exp_v = '0; exp_v[7*DW +: DW] = 16'd1;
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL init_rd_valid got %b want 1", rd_valid); end
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL init_rd_data got %h want %h", rd_data, exp_v); end
    tick();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL init_rd_pulse got %b want 0", rd_valid); end
  endtask

  task automatic test_fill;
    for (int n = 0; n < 7; n++) begin
      wr(1, NW'(n), DW'(10 + n));
      tests++; if (wr_err !== 1'b0 || layer_full[1] !== 1'b0) begin fails++; $display("FAIL fill_w%0d got err=%b full=%b want 0 0", n, wr_err, layer_full[1]); end
    end
    tick();
    tests++; if (layer_full !== 4'b0011) begin fails++; $display("FAIL fill_full got %b want 0011", layer_full); end
    rd(1);
    for (int n = 0; n < 7; n++) exp_v[n*DW +: DW] = DW'(10 + n);
    exp_v[7*DW +: DW] = 16'd1;
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL fill_rd got %h want %h", rd_data, exp_v); end
  endtask

  task automatic test_errors;
    wr(0, 0, 16'h1234);
    tests++; if (wr_err !== 1'b1) begin fails++; $display("FAIL err_layer0 got %b want 1", wr_err); end
    tick();
    tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL err_pulse got %b want 0", wr_err); end
    wr(1, 7, 16'h1234);
    tests++; if (wr_err !== 1'b1) begin fails++; $display("FAIL err_bias got %b want 1", wr_err); end
    wr(5, 0, 16'h1234);
    tests++; if (wr_err !== 1'b1) begin fails++; $display("FAIL err_layer5 got %b want 1", wr_err); end
    tick();
    tests++; if (layer_full !== 4'b0011) begin fails++; $display("FAIL err_full got %b want 0011", layer_full); end
    rd(1);
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL err_rd1 got %h want %h", rd_data, exp_v); end
    rd(3);
    exp_v = '0; exp_v[7*DW +: DW] = 16'd1;
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL err_rd3 got %h want %h", rd_data, exp_v); end
    for (int n = 0; n < NN; n++) master_in[n*DW +: DW] = DW'(16'h0100 + n);
    rd(0);
    tests++; if (rd_data !== master_in || rd_err !== 1'b0) begin fails++; $display("FAIL rd_master got %h err=%b want %h err=0", rd_data, rd_err, master_in); end
    exp_v = master_in;
    master_in = '0;
    rd(5);
    tests++; if (rd_valid !== 1'b1 || rd_err !== 1'b1) begin fails++; $display("FAIL rd_oob got v=%b e=%b want 1 1", rd_valid, rd_err); end
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL rd_oob_hold got %h want %h", rd_data, exp_v); end
  endtask

  task automatic test_rw_same;
    wr_en = 1; wr_layer = 3; wr_neuron = 2; wr_data = 16'h0055;
    rd_req = 1; rd_layer = 3;
    tick();
    wr_en = 0; rd_req = 0;
    exp_v = '0; exp_v[7*DW +: DW] = 16'd1;
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL rw_old got %h want %h", rd_data, exp_v); end
    exp_v[2*DW +: DW] = 16'h0055;
    tests++; if (last_layer !== exp_v) begin fails++; $display("FAIL last_layer got %h want %h", last_layer, exp_v); end
    rd(3);
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL rw_new got %h want %h", rd_data, exp_v); end
    rd_req = 1; rd_layer = 1;
    tick();
    tests++; if (rd_valid !== 1'b1 || rd_data[6*DW +: DW] !== 16'd16) begin fails++; $display("FAIL b2b_1 got v=%b d=%h want 1 0010", rd_valid, rd_data[6*DW +: DW]); end
    rd_layer = 3;
    tick();
    rd_req = 0;
    tests++; if (rd_valid !== 1'b1 || rd_data !== exp_v) begin fails++; $display("FAIL b2b_2 got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_v); end
  endtask

  task automatic test_clear;
    clr_en = 1; clr_layer = 1;
    wr(1, 4, 16'h0044);
    clr_en = 0;
    tests++; if (layer_full[1] !== 1'b1) begin fails++; $display("FAIL clr_lag got %b want 1", layer_full[1]); end
    tick();
    tests++; if (layer_full[1] !== 1'b0) begin fails++; $display("FAIL clr_full got %b want 0", layer_full[1]); end
    for (int n = 0; n < 6; n++) if (n != 4) wr(1, NW'(n), DW'(10 + n));
    tick();
    tests++; if (layer_full[1] !== 1'b0) begin fails++; $display("FAIL clr_partial got %b want 0", layer_full[1]); end
    wr(1, 6, 16'd16);
    tick();
    tests++; if (layer_full[1] !== 1'b1) begin fails++; $display("FAIL clr_refill got %b want 1", layer_full[1]); end
    rd(1);
    for (int n = 0; n < 7; n++) exp_v[n*DW +: DW] = DW'(10 + n);
    exp_v[4*DW +: DW] = 16'h0044; exp_v[7*DW +: DW] = 16'd1;
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL clr_data got %h want %h", rd_data, exp_v); end
  endtask

  task automatic test_relu;
    wr(2, 0, 16'hFFF0);
    rd(2);
    exp_v = '0; exp_v[7*DW +: DW] = 16'd1;
`ifdef LAYER_ACT_BUFFER_RELU_EN
    exp_v[0 +: DW] = 16'h0000;
`else
    exp_v[0 +: DW] = 16'hFFF0;
`endif
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL relu got %h want %h", rd_data, exp_v); end
  endtask

  task automatic test_reset_mid;
    int n;
    rd_req = 1; rd_layer = 1; RST = 1;
    tick();
    rd_req = 0;
    tests++; if (rd_valid !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL mid_rst got v=%b r=%b want 0 0", rd_valid, ready); end
    tests++; if (layer_full !== 4'b0001) begin fails++; $display("FAIL mid_full got %b want 0001", layer_full); end
    RST = 0;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin tick(); n++; end
    tests++; if (n !== 4) begin fails++; $display("FAIL mid_init_len got %0d want 4", n); end
    rd(1);
    exp_v = '0; exp_v[7*DW +: DW] = 16'd1;
    tests++; if (rd_data !== exp_v) begin fails++; $display("FAIL mid_sweep got %h want %h", rd_data, exp_v); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_errors();
    test_rw_same();
    test_clear();
    test_relu();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/layer_act_buffer.md
Name: layer_act_buffer

Overview:
- Parametrised per-layer activation store for the feed-forward accelerator; generalises the fixed-size Y activation RAM.
- Neuron engines write one activation per cycle, addressed by layer/neuron.
- The sequencer reads a whole layer vector, with layer 0 mapped to the external master input.
- Adds a post-reset initialisation sweep, per-layer completion tracking, layer clear, and error flags.

Parameters:
- DATA_W, 16, activation width, signed two's-complement fixed point.
- MAX_NEURONS, 8, neurons per layer vector; index MAX_NEURONS-1 is the bias slot.
- MAX_DEPTH, 4, layer count; layer 0 is master input, layers 1..MAX_DEPTH-1 are stored.
- LAYER_W, $clog2(MAX_DEPTH), layer index width.
- NEURON_W, $clog2(MAX_NEURONS), neuron index width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- ready  out  1  high when init sweep is done and requests are accepted.
- wr_en  in  1  write strobe.
- wr_layer  in  LAYER_W  write layer index.
- wr_neuron  in  NEURON_W  write neuron index.
- wr_data  in  DATA_W  activation value.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- clr_en  in  1  clear completion mask of clr_layer.
- clr_layer  in  LAYER_W  layer to clear.
- rd_req  in  1  read request.
- rd_layer  in  LAYER_W  read layer index.
- master_in  in  MAX_NEURONS*DATA_W  external input vector (layer 0).
- rd_valid  out  1  one-cycle pulse, read data valid.
- rd_err  out  1  pulses with rd_valid when the read was out of range.
- rd_data  out  MAX_NEURONS*DATA_W  registered layer vector, neuron i at bits [i*DATA_W +: DATA_W].
- last_layer  out  MAX_NEURONS*DATA_W  combinational view of stored layer MAX_DEPTH-1.
- layer_full  out  MAX_DEPTH  bit l high when all non-bias neurons of layer l have been written since the last clear; bit 0 is always 1.

Behaviour:
- Reset (RST high at a CLK edge): state<=INIT, init counter<=1, ready<=0, rd_valid<=0, rd_err<=0, wr_err<=0, rd_data<=0, all completion masks<=0.
- RST asserted mid-operation restarts INIT unconditionally; any in-flight read is dropped (rd_valid stays 0).
- INIT state:
  - One stored layer per cycle, counter 1..MAX_DEPTH-1.
  - Each swept layer gets neurons 0..MAX_NEURONS-2 set to 0 and the bias slot set to 1 (value 1 in DATA_W, LSB).
  - Transition to IDLE after the layer MAX_DEPTH-1 sweep cycle; ready rises the following cycle.
  - INIT lasts MAX_DEPTH-1 cycles. wr_en, rd_req and clr_en are ignored with no error pulses.
- IDLE state (ready=1):
  - Reads and writes are both accepted in the same cycle.
- Write (wr_en=1):
  - Accepted when 1 <= wr_layer <= MAX_DEPTH-1 and wr_neuron <= MAX_NEURONS-2.
  - On accept: store wr_data and set the completion mask bit.
  - Otherwise nothing changes and wr_err=1 the next cycle. This covers layer 0, out-of-range layer, bias slot, and out-of-range neuron.
- Read (rd_req=1):
  - rd_valid=1 exactly one cycle later.
  - rd_layer==0: rd_data=master_in as sampled on the request edge.
  - 1 <= rd_layer <= MAX_DEPTH-1: rd_data is the stored vector.
  - rd_layer >= MAX_DEPTH: rd_err=1 and rd_data holds its previous value.
  - Back-to-back requests give back-to-back rd_valid.
- Read and write to the same layer in the same cycle: read-before-write; the read returns the old value.
- Clear (clr_en=1): zeroes the completion mask of clr_layer; data is untouched. Clear of layer 0 or an out-of-range layer has no effect.
- Simultaneous clear and accepted write to the same layer: clear applies first, so only the written neuron's mask bit ends up set.
- layer_full is registered and updates the cycle after the mask changes.
- Bias slots are never writable after INIT and always read as 1.

Optional Feature:
- Macro: LAYER_ACT_BUFFER_RELU_EN.
- Defined: accepted writes store max(wr_data, 0), so a negative signed value is stored as 0.
- Undefined: wr_data is stored verbatim.
- Bias, reads, and error behaviour are identical in both builds.

Test Plan:
- Release RST, MAX_DEPTH=4 -> ready=0 for 3 cycles then 1; read layer 2 -> rd_data neurons 0..6 = 0, neuron 7 = 1, rd_valid 1 cycle after request.
- Write layer 1 neurons 0..6 with values 10..16 -> layer_full[1] rises the cycle after the 7th write; read layer 1 returns 10..16 plus bias 1.
- Write layer 0, write neuron 7, write layer 5 -> wr_err pulses each, storage and masks unchanged.
- Same-cycle write layer 3 neuron 2 = 0x0055 and read layer 3 -> read returns old 0; next read returns 0x0055; last_layer reflects 0x0055 at neuron 2.
- clr_en layer 1 with a write to layer 1 neuron 4 in the same cycle -> layer_full[1]=0, only mask bit 4 set; assert RST during a read -> no rd_valid, INIT restarts.
- With LAYER_ACT_BUFFER_RELU_EN: write 0xFFF0 -> reads back 0; without it -> reads back 0xFFF0.
